// File: rtl/prog_loader.sv
// Program loader: streams an address word then data words into memory writes, one cycle after each transfer.
// Optional PROG_LOADER_CHECKSUM_EN: the in_last data word is a 16-bit checksum compared against the sum of written words.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] count,
  output logic        chk_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] ptr;
  logic        xfer;
  logic        wr;
  logic        launch;

  assign xfer   = in_valid && in_ready;
  assign launch = start && (state == IDLE || state == DONE);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] sum;
  // The in_last data word carries the checksum and is never written.
  assign wr = (state == DATA) && xfer && !in_last;
`else
  assign wr = (state == DATA) && xfer;
  assign chk_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = (state == ADDR) || (state == DATA);
    busy      = (state == ADDR) || (state == DATA);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = ADDR;
      ADDR:    if (xfer) state_nxt = in_last ? DONE : DATA;
      DATA:    if (xfer && in_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum       <= '0;
      chk_err   <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      mem_we <= wr;
      if (wr) begin
        mem_addr  <= ptr;
        mem_wdata <= in_data;
        ptr       <= ptr + 16'd1;
        count     <= count + 16'd1;
      end
      if (launch) count <= '0;
      if (state == ADDR && xfer) ptr <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
      if (wr) sum <= sum + in_data;
      if (launch) begin
        sum     <= '0;
        chk_err <= 1'b0;
      end
      if (state == ADDR && xfer && in_last) chk_err <= 1'b1;
      if (state == DATA && xfer && in_last) chk_err <= (in_data != sum);
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; build with or without PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [15:0] in_data;
  logic        in_ready, mem_we, busy, done, chk_err;
  logic [15:0] mem_addr, mem_wdata, count;
  logic [15:0] tsum;
  int checks = 0;
  int errors = 0;

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .count(count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    tsum = '0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_count", count, 0);
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] a, input logic [15:0] d, input logic [15:0] c);
    chk({tag, "_we"}, mem_we, 1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
    chk({tag, "_count"}, count, c);
  endtask

  // Final data word: a plain last-flagged write, or a written word followed by its checksum.
  task automatic finish_load(input string tag, input logic [15:0] d, input logic [15:0] a, input logic [15:0] c);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(d, 1'b0);
    wr_chk(tag, a, d, c);
    tsum = tsum + d;
    send(tsum, 1'b1);
    chk({tag, "_ck_we"}, mem_we, 0);
`else
    send(d, 1'b1);
    wr_chk(tag, a, d, c);
`endif
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_cnt_end"}, count, c);
    chk({tag, "_chk"}, chk_err, 0);
    step();
    chk({tag, "_we_off"}, mem_we, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; tsum = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdy", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_chk", chk_err, 0);
    rst = 1'b0;
    // Input while idle does nothing
    in_valid = 1'b1; in_data = 16'h1111; step(); in_valid = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_we", mem_we, 0);

    // Basic load: x3000 <- x1234, x5678
    do_start();
    chk("basic_rdy", in_ready, 1);
    send(16'h3000, 1'b0);
    chk("basic_addr_we", mem_we, 0);
    send(16'h1234, 1'b0);
    wr_chk("basic_w0", 16'h3000, 16'h1234, 1);
    tsum = tsum + 16'h1234;
    finish_load("basic_w1", 16'h5678, 16'h3001, 2);

    // Input during DONE is ignored
    in_valid = 1'b1; in_data = 16'hDEAD; step(); in_valid = 1'b0;
    chk("done_ign_we", mem_we, 0);
    chk("done_ign_cnt", count, 2);

    // Valid gap, with start and garbage last-flag ignored
    do_start();
    send(16'h4000, 1'b0);
    send(16'hAAAA, 1'b0);
    wr_chk("gap_w0", 16'h4000, 16'hAAAA, 1);
    tsum = tsum + 16'hAAAA;
    in_last = 1'b1; in_data = 16'h9999; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      chk("gap_we", mem_we, 0);
      chk("gap_busy", busy, 1);
      chk("gap_cnt", count, 1);
    end
    in_last = 1'b0;
    send(16'hBBBB, 1'b0);
    wr_chk("gap_w1", 16'h4001, 16'hBBBB, 2);
    tsum = tsum + 16'hBBBB;
    finish_load("gap_w2", 16'hCCCC, 16'h4002, 3);

    // Pointer wrap
    do_start();
    send(16'hFFFF, 1'b0);
    send(16'h1111, 1'b0);
    wr_chk("wrap_w0", 16'hFFFF, 16'h1111, 1);
    tsum = tsum + 16'h1111;
    finish_load("wrap_w1", 16'h2222, 16'h0000, 2);

    // Reset mid-load, with a transfer and start in the reset cycle
    do_start();
    send(16'h5000, 1'b0);
    send(16'h0001, 1'b0);
    wr_chk("abort_w0", 16'h5000, 16'h0001, 1);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 16'h0002;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    chk("abort_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", count, 0);
    chk("abort_rdy", in_ready, 0);
    step();
    chk("abort_we2", mem_we, 0);
    chk("abort_idle", busy, 0);
    do_start();
    send(16'h6000, 1'b0);
    finish_load("reload", 16'h0007, 16'h6000, 1);

    // Two back-to-back images
    do_start();
    send(16'h0000, 1'b0);
    send(16'h000A, 1'b0);
    wr_chk("two_a0", 16'h0000, 16'h000A, 1);
    tsum = tsum + 16'h000A;
    finish_load("two_a1", 16'h000B, 16'h0001, 2);
    do_start();
    send(16'h3000, 1'b0);
    finish_load("two_b0", 16'h000C, 16'h3000, 1);

    // Address word carrying last
    do_start();
    send(16'h8000, 1'b1);
    chk("alast_we", mem_we, 0);
    chk("alast_done", done, 1);
    chk("alast_cnt", count, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("alast_chk", chk_err, 1);

    // Checksum good: 1+2 = 3
    do_start();
    send(16'h3000, 1'b0);
    send(16'h0001, 1'b0);
    wr_chk("cks_w0", 16'h3000, 16'h0001, 1);
    send(16'h0002, 1'b0);
    wr_chk("cks_w1", 16'h3001, 16'h0002, 2);
    send(16'h0003, 1'b1);
    chk("cks_we", mem_we, 0);
    chk("cks_cnt", count, 2);
    chk("cks_done", done, 1);
    chk("cks_ok", chk_err, 0);
    // Checksum bad
    do_start();
    chk("cks_clr", chk_err, 0);
    send(16'h3000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    send(16'h0004, 1'b1);
    chk("cksb_we", mem_we, 0);
    chk("cksb_cnt", count, 2);
    chk("cksb_err", chk_err, 1);
`else
    chk("alast_chk", chk_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 clk  input  1  single system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  one-cycle pulse; begins a load.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_data  input  16  upstream word: first word of a load is the start address, the rest are memory words.
REQ-006 in_last  input  1  marks the final word of a load; qualified by in_valid.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
REQ-008 mem_we  output  1  memory write strobe, one cycle per word.
REQ-009 mem_addr  output  16  memory write address.
REQ-010 mem_wdata  output  16  memory write data.
REQ-011 busy  output  1  load in progress (ADDR or DATA state).
REQ-012 done  output  1  level; last load complete.
REQ-013 count  output  16  words written to memory in the current or last load.
REQ-014 chk_err  output  1  checksum mismatch flag (see Configuration).

Function
REQ-015 The block SHALL implement states IDLE, ADDR, DATA, DONE.
REQ-016 IDLE: in_ready=0; start -> ADDR, with count cleared, done=0, and chk_err=0.
REQ-017 ADDR: in_ready=1; on transfer, ptr<=in_data and go to DATA. If in_last is also set, go to DONE with count=0 and nothing written.
REQ-018 DATA: in_ready=1; on transfer, the next cycle SHALL show mem_we=1, mem_addr=ptr, mem_wdata=in_data; ptr and count increment by 1.
REQ-019 DATA with in_last on a transfer SHALL write that word and go to DONE, unless Configuration overrides this.
REQ-020 Write latency SHALL be exactly one cycle from transfer to mem_we. Back-to-back transfers SHALL produce back-to-back writes at full throughput.
REQ-021 ptr SHALL wrap xFFFF -> x0000. count SHALL wrap modulo 2^16.
REQ-022 DONE: in_ready=0, done=1; start -> ADDR, which begins a new load (second program image) with count cleared. Memory is not cleared.
REQ-023 start SHALL be ignored in ADDR and DATA.
REQ-024 in_valid with in_ready=0 SHALL have no effect. in_data and in_last SHALL be ignored when in_valid=0.
REQ-025 mem_we SHALL be 0 in every cycle not following a DATA write transfer.
REQ-026 busy SHALL be 1 exactly in ADDR and DATA.

Reset
REQ-027 rst SHALL force state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, count=0, chk_err=0, ptr=0 and sum=0.
REQ-028 rst mid-load SHALL abort the load. Words already written remain in memory, and a write staged for the reset cycle SHALL NOT be issued.
REQ-029 rst SHALL take priority over start and any transfer in the same cycle.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN controls checksum checking.
REQ-031 Defined: a 16-bit sum (modulo 2^16) of all words written in DATA SHALL be accumulated and cleared at start. The DATA word carrying in_last SHALL be a checksum and is not written and not counted. On entering DONE, chk_err=1 iff checksum != sum. in_last on the address word SHALL set chk_err=1.
REQ-032 Not defined: chk_err SHALL be tied 0, no accumulator exists, and the in_last word is written as data.

Verification
REQ-033 rst; start; stream x3000, x1234, x5678(last) -> writes mem[x3000]=x1234 and mem[x3001]=x5678 on consecutive cycles; done=1, count=2.
REQ-034 Upstream drops in_valid for 3 cycles between data words -> no mem_we during the gap; addresses stay contiguous; count correct.
REQ-035 Address xFFFF followed by 2 data words -> writes to xFFFF then x0000.
REQ-036 Assert rst after 1 of 3 data words -> state IDLE next cycle, no further mem_we, done=0, count=0. A subsequent full load succeeds.
REQ-037 Two loads (x0000 with 2 words, then start; x3000 with 1 word) -> both regions written; count=1 after the second load.
REQ-038 CHECKSUM_EN: x3000, x0001, x0002, x0003(last) -> 2 words written, chk_err=0. Same stream with last=x0004 -> chk_err=1.
